// File: rtl/regfile_sb.sv
// regfile_sb -- two-read / one-write register file with an issue-time
// scoreboard and a sequential clear engine.
//
// Ports:
//   clk, rst_n            core clock (rising edge), asynchronous active-low reset
//   rd_addr1/rd_addr2     read indices
//   rd_data1/rd_data2     combinational read data (write-to-read bypass while idle)
//   rd_busy1/rd_busy2     read register has an outstanding producer
//   wr_en/wr_addr/wr_data writeback port; also retires the scoreboard bit
//   iss_en/iss_addr       issue port; marks iss_addr as pending
//   clr_req               start a full-file clear (ignored while clearing)
//   clr_busy              clear engine active (SWEEP or DONE)
//   clr_done              one-cycle pulse in the final clear cycle
//
// Configuration macro: REGFILE_ZERO_REG_EN
//   defined   -> register 0 reads as zero, is never written, never busy
//   undefined -> register 0 is an ordinary register
//
// Port handshakes: there is no valid/ready pairing here. wr_en, iss_en and
// clr_req are single-cycle commands sampled at the rising edge; while
// clr_busy is high all three are dropped without any back-pressure, so the
// issuer must hold off on its own.
//
// The clear FSM state is available as state_q for hierarchical probing;
// clr_busy/clr_done are its decoded outputs.

module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic is_idle;
    logic wr_live;   // writeback accepted this cycle (drives bypass and busy retire)
    logic wr_store;  // writeback actually updates the array
    logic iss_set;   // issue actually marks a register pending
    logic rd1_zero;
    logic rd2_zero;

    assign is_idle = (state_q == ST_IDLE);
    assign wr_live = wr_en && is_idle;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_store = wr_live && (wr_addr != '0);
    assign iss_set  = iss_en && is_idle && (iss_addr != '0);
    assign rd1_zero = (rd_addr1 == '0);
    assign rd2_zero = (rd_addr2 == '0);
`else
    assign wr_store = wr_live;
    assign iss_set  = iss_en && is_idle;
    assign rd1_zero = 1'b0;
    assign rd2_zero = 1'b0;
`endif

    // Next-state: array, scoreboard and clear FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_store) begin
                    mem_d[wr_addr] = wr_data;
                end
                if (wr_live) begin
                    busy_d[wr_addr] = 1'b0;
                end
                // Applied after the retire so a same-index issue wins: the
                // newly issued producer supersedes the one writing back.
                if (iss_set) begin
                    busy_d[iss_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                mem_d[idx_q]  = '0;
                busy_d[idx_q] = 1'b0;
                idx_d         = idx_q + ADDR_W'(1);
                // Terminate on the compare; idx wraps to 0 harmlessly.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports. Outputs are forced low while reset is held so a bypass
    // from a live writeback cannot leak through during reset.
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
        if (wr_live && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;  // value arriving this cycle is not a hazard
        end
        if (!rst_n || rd1_zero) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = mem_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
        if (wr_live && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
        if (!rst_n || rd2_zero) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    assign clr_busy = (state_q != ST_IDLE);
    assign clr_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- self-checking bench for regfile_sb.
// Reference model: plain arrays of register values and pending flags plus a
// clear-progress counter; expected read values are derived from them.

module tb_regfile_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              rd_busy1, rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              clr_req;
  logic              clr_busy, clr_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  int total;
  int bad;
  logic [DATA_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem  [DEPTH];
  logic              m_busy [DEPTH];
  bit                m_clearing;
  int                m_cyc;  // 0..DEPTH-1 sweeping, DEPTH = final cycle

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_cyc      = 0;
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (!rst_n) return '0;
    if (ZERO_EN && a == 0) return '0;
    if (!m_clearing && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (!rst_n) return 1'b0;
    if (ZERO_EN && a == 0) return 1'b0;
    if (!m_clearing && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_clr_busy();
    return rst_n && m_clearing;
  endfunction

  function automatic logic exp_clr_done();
    return rst_n && m_clearing && (m_cyc == DEPTH);
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_clearing) begin
      if (wr_en && !(ZERO_EN && wr_addr == 0)) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (iss_en && !(ZERO_EN && iss_addr == 0)) m_busy[iss_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_cyc      = 0;
      end
    end else if (m_cyc < DEPTH) begin
      m_mem[m_cyc]  = '0;
      m_busy[m_cyc] = 1'b0;
      m_cyc++;
    end else begin
      m_clearing = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    clr_req  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a);
      rd_addr2 = ADDR_W'(DEPTH - 1 - a);
      wr_en    = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = DATA_W'($urandom);
      iss_en   = 1'b1;
      iss_addr = ADDR_W'(a);
      clr_req  = 1'b1;
      #1;
      total++;
      if (rd_data1 !== '0 || rd_data2 !== '0) begin
        bad++;
        $display("FAIL reset_data a=%0d got=%h/%h exp=0000/0000", a, rd_data1, rd_data2);
      end
      total++;
      if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_flags a=%0d got=%b%b%b%b exp=0000", a, rd_busy1, rd_busy2, clr_busy, clr_done);
      end
      tick();
    end
    drive_idle();
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a);
      rd_addr2 = ADDR_W'(a);
      #1;
      total++;
      if (rd_data1 !== 16'h0000 || rd_busy2 !== 1'b0) begin
        bad++;
        $display("FAIL post_reset a=%0d got=%h busy=%b exp=0000 busy=0", a, rd_data1, rd_busy2);
      end
      tick();
    end
  endtask

  task automatic test_write_bypass();
    drive_idle();
    wr_en    = 1'b1;
    wr_addr  = 4'd5;
    wr_data  = 16'hBEEF;
    rd_addr1 = 4'd5;
    #1;
    total++;
    if (rd_data1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass got=%h exp=BEEF", rd_data1);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if (rd_data1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL stored got=%h exp=BEEF", rd_data1);
    end
    wr_data = 16'h1234;
    #1;
    total++;
    if (rd_data1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL no_bypass_wr_en0 got=%h exp=BEEF", rd_data1);
    end
    tick();
    total++;
    if (rd_data1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL no_write_wr_en0 got=%h exp=BEEF", rd_data1);
    end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    rd_addr2 = 4'd3;
    iss_en   = 1'b1;
    iss_addr = 4'd3;
    #1;
    total++;
    if (rd_busy2 !== 1'b0) begin
      bad++;
      $display("FAIL busy_before_edge got=%b exp=0", rd_busy2);
    end
    tick();
    iss_en = 1'b0;
    #1;
    total++;
    if (rd_busy2 !== 1'b1) begin
      bad++;
      $display("FAIL busy_set got=%b exp=1", rd_busy2);
    end
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'h0033;
    #1;
    total++;
    if (rd_busy2 !== 1'b0) begin
      bad++;
      $display("FAIL busy_wb_mask got=%b exp=0", rd_busy2);
    end
    tick();
    wr_en = 1'b0;
    #1;
    total++;
    if (rd_busy2 !== 1'b0) begin
      bad++;
      $display("FAIL busy_cleared got=%b exp=0", rd_busy2);
    end
    rd_addr2 = 4'd7;
    wr_en    = 1'b1;
    wr_addr  = 4'd7;
    wr_data  = 16'h0077;
    iss_en   = 1'b1;
    iss_addr = 4'd7;
    tick();
    drive_idle();
    #1;
    total++;
    if (rd_busy2 !== 1'b1) begin
      bad++;
      $display("FAIL set_wins got=%b exp=1", rd_busy2);
    end
  endtask

  task automatic test_zero_reg();
    logic [DATA_W-1:0] want_byp;
    logic [DATA_W-1:0] want_data;
    logic              want_busy;
    want_byp  = ZERO_EN ? 16'h0000 : 16'hFFFF;
    want_data = ZERO_EN ? 16'h0000 : 16'hFFFF;
    want_busy = ZERO_EN ? 1'b0 : 1'b1;
    drive_idle();
    rd_addr1 = 4'd0;
    wr_en    = 1'b1;
    wr_addr  = 4'd0;
    wr_data  = 16'hFFFF;
    iss_en   = 1'b1;
    iss_addr = 4'd0;
    #1;
    total++;
    if (rd_data1 !== want_byp) begin
      bad++;
      $display("FAIL zero_bypass got=%h exp=%h", rd_data1, want_byp);
    end
    tick();
    drive_idle();
    #1;
    total++;
    if (rd_data1 !== want_data || rd_busy1 !== want_busy) begin
      bad++;
      $display("FAIL zero_reg got=%h busy=%b exp=%h busy=%b", rd_data1, rd_busy1, want_data, want_busy);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] got;
    for (int c = 0; c < 400; c++) begin
      rd_addr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data  = DATA_W'($urandom);
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      clr_req  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) rd_addr1 = wr_addr;
      #1;
      exp_q.push_back(exp_data(rd_addr1));
      exp_q.push_back(exp_data(rd_addr2));
      got = exp_q.pop_front();
      total++;
      if (rd_data1 !== got) begin
        bad++;
        $display("FAIL rnd_data1 c=%0d a=%0d got=%h exp=%h", c, rd_addr1, rd_data1, got);
      end
      got = exp_q.pop_front();
      total++;
      if (rd_data2 !== got) begin
        bad++;
        $display("FAIL rnd_data2 c=%0d a=%0d got=%h exp=%h", c, rd_addr2, rd_data2, got);
      end
      total++;
      if (rd_busy1 !== exp_busy(rd_addr1) || rd_busy2 !== exp_busy(rd_addr2)) begin
        bad++;
        $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, rd_busy1, rd_busy2,
                 exp_busy(rd_addr1), exp_busy(rd_addr2));
      end
      total++;
      if (clr_busy !== exp_clr_busy() || clr_done !== exp_clr_done()) begin
        bad++;
        $display("FAIL rnd_clr c=%0d got=%b%b exp=%b%b", c, clr_busy, clr_done,
                 exp_clr_busy(), exp_clr_done());
      end
      tick();
    end
    drive_idle();
    for (int n = 0; n < 40 && m_clearing; n++) tick();
  endtask

  task automatic test_clear();
    drive_idle();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en    = 1'b1;
      wr_addr  = ADDR_W'(i);
      wr_data  = DATA_W'(16'h00A0 + i);
      iss_en   = 1'b1;
      iss_addr = ADDR_W'(i);
      tick();
    end
    drive_idle();
    clr_req = 1'b1;
    tick();
    for (int k = 0; k <= DEPTH; k++) begin
      clr_req  = ($urandom_range(0, 1) == 1);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data  = DATA_W'($urandom);
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr2 = wr_addr;
      #1;
      total++;
      if (clr_busy !== 1'b1 || clr_done !== (k == DEPTH)) begin
        bad++;
        $display("FAIL clr_timing k=%0d got=%b%b exp=1%b", k, clr_busy, clr_done, (k == DEPTH));
      end
      total++;
      if (rd_data1 !== exp_data(rd_addr1) || rd_data2 !== exp_data(rd_addr2)) begin
        bad++;
        $display("FAIL clr_read k=%0d got=%h/%h exp=%h/%h", k, rd_data1, rd_data2,
                 exp_data(rd_addr1), exp_data(rd_addr2));
      end
      tick();
    end
    drive_idle();
    #1;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_end got=%b%b exp=00", clr_busy, clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a);
      rd_addr2 = ADDR_W'(a);
      #1;
      total++;
      if (rd_data1 !== 16'h0000 || rd_busy2 !== 1'b0) begin
        bad++;
        $display("FAIL clr_zeroed a=%0d got=%h busy=%b exp=0000 busy=0", a, rd_data1, rd_busy2);
      end
    end
  endtask

  task automatic test_midsweep_reset();
    int n;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en    = 1'b1;
      wr_addr  = ADDR_W'(i);
      wr_data  = DATA_W'($urandom_range(1, 16'hFFFF));
      iss_en   = 1'b1;
      iss_addr = ADDR_W'(DEPTH - 1 - i);
      tick();
    end
    drive_idle();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags got=%b%b exp=00", clr_busy, clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a);
      rd_addr2 = ADDR_W'(a);
      #1;
      total++;
      if (rd_data1 !== 16'h0000 || rd_busy2 !== 1'b0) begin
        bad++;
        $display("FAIL midrst_regs a=%0d got=%h busy=%b exp=0000 busy=0", a, rd_data1, rd_busy2);
      end
    end
    @(negedge clk);
    rst_n   = 1'b1;
    clr_req = 1'b1;
    #1;
    total++;
    if (clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got=%b exp=0", clr_busy);
    end
    tick();
    clr_req = 1'b0;
    total++;
    if (clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_restart got=%b exp=1", clr_busy);
    end
    n = 0;
    while (clr_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL midrst_done_latency got=%0d exp=%0d (40 = timeout)", n, DEPTH);
    end
    tick();
    total++;
    if (clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_back_idle got=%b exp=0", clr_busy);
    end
  endtask

  // ---------------- sequencing / report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_zero_reg();
    test_random();
    test_clear();
    test_midsweep_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
